// File: rtl/adc_pkg.sv
// Shared types, constants and helpers for the ADC frame packer.
package adc_pkg;

   typedef logic [15:0] sample_t;
   typedef logic [31:0] axis_word_t;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_CAPTURE = 1'b1
   } state_e;

   localparam logic [3:0] TKEEP_ALL = 4'hF;

   // First sample lands in the upper half-word.
   function automatic axis_word_t pack_word(input sample_t first, input sample_t second);
      return {first, second};
   endfunction

endpackage

// File: rtl/axis_fifo_fwft.sv
// First-word-fall-through FIFO; a push is accepted when full if a pop happens in the same cycle.
module axis_fifo_fwft #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             wr_en_s;
   logic             rd_en_s;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];

   // Handshake qualification: pop only real data, push when space exists now or is freed this cycle.
   always_comb begin
      rd_en_s = pop_i && !empty_o;
      wr_en_s = push_i && (!full_o || rd_en_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (rd_en_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + (AW+1)'(wr_en_s) - (AW+1)'(rd_en_s);
      end
   end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs 16-bit ADC samples into fixed-length 32-bit AXI4-Stream frames.
// Define ADC_FRAME_PACKER_TEST_PATTERN_EN to replace SAMPLE with an incrementing test counter.
module adc_frame_packer
   import adc_pkg::*;
#(
   parameter int FRAME_WORDS = 1024,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic        aclk_i,
   input  logic        aresetn_i,
   input  logic        sample_valid_i,
   input  logic [15:0] sample_i,
   input  logic        start_i,
   output logic        tvalid_o,
   output logic [31:0] tdata_o,
   output logic [3:0]  tkeep_o,
   output logic        tlast_o,
   input  logic        tready_i,
   output logic        busy_o,
   output logic        overflow_o,
   input  logic        overflow_clr_i
);
   localparam int CW = $clog2(2 * FRAME_WORDS) + 1;
   localparam logic [CW-2:0] LAST_WORD_IDX = (CW-1)'(FRAME_WORDS - 1);

   state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   sample_t    half_q, half_d;
   logic       lw_vld_q, lw_vld_d;
   axis_word_t lw_data_q, lw_data_d;
   logic       ovf_q, ovf_d;

   logic          start_acc_s;
   logic          take_s;
   logic [CW-1:0] idx_s;
   sample_t       val_s;
   logic          word_done_s;
   logic          word_last_s;
   logic          space_s;
   logic          push_s;
   logic [32:0]   push_data_s;
   logic          ovf_set_s;
   logic [32:0]   fifo_rdata_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;

   assign start_acc_s = (state_q == ST_IDLE) && start_i && !lw_vld_q;
   assign take_s      = sample_valid_i && ((state_q == ST_CAPTURE) || start_acc_s);
   assign idx_s       = start_acc_s ? '0 : cnt_q;
   assign space_s     = !fifo_full_s || (tready_i && !fifo_empty_s);

`ifdef ADC_FRAME_PACKER_TEST_PATTERN_EN
   sample_t pat_q, pat_d;
   logic    unused_s;

   assign unused_s = ^sample_i;
   assign val_s    = start_acc_s ? 16'h0000 : pat_q;

   // Test counter restarts at each accepted START and advances per valid sample slot.
   always_comb begin
      if (take_s) begin
         pat_d = val_s + 16'h0001;
      end else if (start_acc_s) begin
         pat_d = 16'h0000;
      end else begin
         pat_d = pat_q;
      end
   end

   // Test counter register.
   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         pat_q <= 16'h0000;
      end else begin
         pat_q <= pat_d;
      end
   end
`else
   assign val_s = sample_i;
`endif

   // Framing, pairing and overflow / last-word arbitration.
   always_comb begin
      state_d     = state_q;
      cnt_d       = start_acc_s ? '0 : cnt_q;
      half_d      = half_q;
      lw_vld_d    = lw_vld_q;
      lw_data_d   = lw_data_q;
      word_done_s = 1'b0;
      word_last_s = 1'b0;
      push_s      = 1'b0;
      push_data_s = '0;
      ovf_set_s   = 1'b0;

      if (start_acc_s) begin
         state_d = ST_CAPTURE;
      end else begin
         state_d = state_q;
      end

      if (take_s) begin
         cnt_d = idx_s + CW'(1);
         if (!idx_s[0]) begin
            half_d = val_s;
         end else begin
            word_done_s = 1'b1;
            word_last_s = (idx_s[CW-1:1] == LAST_WORD_IDX);
         end
      end else begin
         half_d = half_q;
      end

      // A parked final word blocks new frames, so it never competes with a fresh word.
      if (lw_vld_q) begin
         if (space_s) begin
            push_s      = 1'b1;
            push_data_s = {1'b1, lw_data_q};
            lw_vld_d    = 1'b0;
         end else begin
            lw_vld_d = 1'b1;
         end
      end else if (word_done_s) begin
         if (space_s) begin
            push_s      = 1'b1;
            push_data_s = {word_last_s, pack_word(half_q, val_s)};
         end else if (word_last_s) begin
            lw_vld_d  = 1'b1;
            lw_data_d = pack_word(half_q, val_s);
         end else begin
            ovf_set_s = 1'b1;
         end
         if (word_last_s) begin
            state_d = ST_IDLE;
         end else begin
            state_d = ST_CAPTURE;
         end
      end else begin
         lw_vld_d = lw_vld_q;
      end

      if (ovf_set_s) begin
         ovf_d = 1'b1;
      end else if (overflow_clr_i) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Control and datapath registers.
   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         half_q    <= 16'h0000;
         lw_vld_q  <= 1'b0;
         lw_data_q <= 32'h0000_0000;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         lw_vld_q  <= lw_vld_d;
         lw_data_q <= lw_data_d;
         ovf_q     <= ovf_d;
      end
   end

   axis_fifo_fwft #(
      .WIDTH (33),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (aclk_i),
      .rst_ni  (aresetn_i),
      .push_i  (push_s),
      .wdata_i (push_data_s),
      .pop_i   (tready_i),
      .rdata_o (fifo_rdata_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   assign tvalid_o            = !fifo_empty_s;
   assign {tlast_o, tdata_o}  = fifo_rdata_s;
   assign tkeep_o             = TKEEP_ALL;
   assign busy_o              = (state_q == ST_CAPTURE) || lw_vld_q;
   assign overflow_o          = ovf_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Randomized scoreboard bench for adc_frame_packer against a frame-level reference model.
module tb_adc_frame_packer;
   localparam int FW    = 8;
   localparam int DEPTH = 4;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] sample = 16'h0000;
   logic        start = 1'b0;
   logic        tready = 1'b0;
   logic        ovf_clr = 1'b0;
   logic        tvalid_o, tlast_o, busy_o, overflow_o;
   logic [31:0] tdata_o;
   logic [3:0]  tkeep_o;

   int checks = 0;
   int errors = 0;

   logic [32:0] exp_q[$];

   bit          m_capt, m_pend, m_ovf;
   int          m_idx, m_cnt;
   logic [15:0] m_half, m_pat;
   logic [31:0] m_lastword;

   adc_frame_packer #(.FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)) dut (
      .aclk_i         (aclk),
      .aresetn_i      (aresetn),
      .sample_valid_i (sample_valid),
      .sample_i       (sample),
      .start_i        (start),
      .tvalid_o       (tvalid_o),
      .tdata_o        (tdata_o),
      .tkeep_o        (tkeep_o),
      .tlast_o        (tlast_o),
      .tready_i       (tready),
      .busy_o         (busy_o),
      .overflow_o     (overflow_o),
      .overflow_clr_i (ovf_clr)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_capt = 0; m_pend = 0; m_ovf = 0;
      m_idx = 0; m_cnt = 0;
      m_half = 16'h0000; m_pat = 16'h0000; m_lastword = 32'h0;
      exp_q.delete();
   endtask

   // Reference model: one step per clock edge, FIFO tracked as an occupancy count.
   task automatic model_step(input bit sv, input logic [15:0] s, input bit st, input bit tr, input bit clr);
      bit pop, space, push, ovf_set, last;
      logic [15:0] val;
      logic [32:0] pw;
      pop = (m_cnt > 0) && tr;
      space = (m_cnt < DEPTH) || pop;
      push = 0; ovf_set = 0; pw = '0; last = 0;
      if (m_pend) begin
         if (space) begin
            push = 1; pw = {1'b1, m_lastword}; m_pend = 0;
         end
      end else begin
         if (!m_capt && st) begin
            m_capt = 1; m_idx = 0; m_pat = 16'h0000;
         end
         if (m_capt && sv) begin
`ifdef ADC_FRAME_PACKER_TEST_PATTERN_EN
            val = m_pat;
`else
            val = s;
`endif
            m_pat = m_pat + 16'd1;
            if (m_idx % 2 == 0) begin
               m_half = val;
            end else begin
               last = (m_idx / 2 == FW - 1);
               if (space) begin
                  push = 1; pw = {last, m_half, val};
               end else if (last) begin
                  m_pend = 1; m_lastword = {m_half, val};
               end else begin
                  ovf_set = 1;
               end
               if (last) m_capt = 0;
            end
            m_idx++;
         end
      end
      if (push) exp_q.push_back(pw);
      m_cnt = m_cnt - (pop ? 1 : 0) + (push ? 1 : 0);
      if (ovf_set) m_ovf = 1;
      else if (clr) m_ovf = 0;
   endtask

   task automatic cycle(input bit sv, input logic [15:0] s, input bit st, input bit tr, input bit clr);
      @(negedge aclk);
      check("busy", busy_o, m_capt || m_pend);
      check("overflow", overflow_o, m_ovf);
      sample_valid = sv; sample = s; start = st; tready = tr; ovf_clr = clr;
      model_step(sv, s, st, tr, clr);
   endtask

   task automatic do_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      sample_valid = 0; start = 0; tready = 0; ovf_clr = 0;
      #1;
      check("reset_tvalid", tvalid_o, 1'b0);
      check("reset_busy", busy_o, 1'b0);
      model_reset();
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   // Monitor: pops the scoreboard on each handshake and checks stall stability.
   bit          prev_stall = 0;
   logic [32:0] prev_word;
   initial begin
      logic [32:0] exp;
      forever begin
         @(negedge aclk);
         #3;
         if (!aresetn) begin
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               check("hold_tvalid", tvalid_o, 1'b1);
               check("hold_word", {tlast_o, tdata_o}, prev_word);
            end
            if (tvalid_o && tready) begin
               check("tkeep", tkeep_o, 4'hF);
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_word: got %h expected none at %0t", {tlast_o, tdata_o}, $time);
               end else begin
                  exp = exp_q.pop_front();
                  check("word", {tlast_o, tdata_o}, exp);
               end
            end
            prev_stall = tvalid_o && !tready;
            prev_word  = {tlast_o, tdata_o};
         end
      end
   end

   initial begin
      int mode;
      bit tr;
      int guard;
      model_reset();
      @(negedge aclk);
      @(negedge aclk);
      check("rst_tvalid", tvalid_o, 1'b0);
      check("rst_tdata", tdata_o, 32'h0);
      check("rst_tlast", tlast_o, 1'b0);
      check("rst_tkeep", tkeep_o, 4'hF);
      check("rst_busy", busy_o, 1'b0);
      check("rst_overflow", overflow_o, 1'b0);
      aresetn = 1'b1;

      // Directed frame: samples 1..16, always ready.
      cycle(1, 16'd1, 1, 1, 0);
      for (int i = 2; i <= 2 * FW; i++) cycle(1, 16'(i), 0, 1, 0);
      for (int i = 0; i < 6; i++) cycle(0, 16'h0, 0, 1, 0);

      // Overflow frame: downstream stalled, START retried mid-frame and while final word is parked.
      cycle(1, 16'($urandom), 1, 0, 0);
      for (int i = 1; i < 2 * FW; i++) cycle(1, 16'($urandom), (i == 5), 0, 0);
      for (int i = 0; i < 4; i++) cycle(1, 16'($urandom), 1, 0, 0);
      @(negedge aclk);
      check("ovf_directed", overflow_o, 1'b1);
      check("busy_parked", busy_o, 1'b1);
      for (int i = 0; i < 10; i++) cycle(0, 16'h0, 0, 1, 0);
      cycle(0, 16'h0, 0, 1, 1);
      cycle(0, 16'h0, 0, 1, 0);

      // Randomized frames with per-frame back-pressure profile.
      for (int f = 0; f < 60; f++) begin
         mode = int'($urandom_range(0, 2));
         for (int c = 0; c < 40; c++) begin
            if (mode == 0) tr = 1;
            else if (mode == 1) tr = ($urandom_range(0, 1) == 1);
            else tr = ($urandom_range(0, 9) == 0);
            cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) == 0,
                  tr, $urandom_range(0, 19) == 0);
         end
      end

      // Drain, then reset in the middle of a frame after three words.
      for (int i = 0; i < 40; i++) cycle(1, 16'($urandom), 0, 1, 0);
      cycle(1, 16'($urandom), 1, 1, 0);
      for (int i = 1; i < 7; i++) cycle(1, 16'($urandom), 0, 0, 0);
      do_reset();

      // Clean frame after reset, then bounded drain.
      cycle(1, 16'hA001, 1, 1, 0);
      for (int i = 1; i < 2 * FW; i++) cycle(1, 16'($urandom), 0, ($urandom_range(0, 1) == 1), 0);
      guard = 0;
      while ((exp_q.size() != 0 || m_capt || m_pend) && guard < 200) begin
         cycle(1, 16'($urandom), 0, 1, 0);
         guard++;
      end
      for (int i = 0; i < 3; i++) cycle(0, 16'h0, 0, 1, 0);
      check("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
      check("final_tvalid", tvalid_o, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
